serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial W-bit adder: accepts two parallel operands plus carry-in, streams them LSB-first
//   through a single full-adder cell with a registered carry, and returns the parallel sum/carry.
//   Sits upstream of the 1-bit full-adder datapath cell, supplying it one operand bit pair per cycle.
//   Handshakes on both sides (valid/ready).
// PARAMETERS
//   W          4     operand/sum width in bits (W >= 1)
// PORTS
//   clk        in   1   single clock, rising-edge
//   rst_n      in   1   reset, asynchronous, active-low
//   in_valid   in   1   operands a, b, c_in valid
//   in_ready   out  1   block idle, can accept operands
//   a          in   W   operand A
//   b          in   W   operand B
//   c_in       in   1   carry-in
//   sub        in   1   subtract select (present only with SERIAL_ADDER_SUB_EN)
//   out_valid  out  1   sum/c_out valid
//   out_ready  in   1   consumer accepts result
//   sum        out  W   result, {c_out,sum} = a + b + c_in
//   c_out      out  1   carry-out of bit W-1
//   busy       out  1   high in RUN
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; shift regs, carry, count cleared; in_ready=1,
//     out_valid=0, busy=0, sum=0, c_out=0. Reset mid-RUN/DONE aborts, result discarded.
//   - FSM states IDLE, RUN, DONE:
//     IDLE: in_ready=1. On in_valid: load a_sh=a, b_sh=b, carry=c_in, count=0 -> RUN.
//     RUN:  each cycle fa(a_sh[0], b_sh[0], carry) -> s, co; sum_sh={s,sum_sh[W-1:1]};
//           a_sh, b_sh shift right; carry<=co; count++. When count==W-1 -> DONE.
//     DONE: out_valid=1; sum=sum_sh, c_out=carry held stable. On out_ready -> IDLE.
//   - Latency: out_valid rises exactly W cycles after the accepting edge; throughput one op
//     per W+2 cycles minimum (accept, W RUN cycles, handoff).
//   - in_ready=0 in RUN and DONE; in_valid ignored there (no queueing, no overwrite).
//   - out_ready ignored outside DONE. out_valid and out_ready both high -> same-edge return
//     to IDLE; new operand accepted no earlier than the following edge.
//   - Width rule: arithmetic modulo 2^W, carry-out is bit W; no overflow flag.
//   - W=1: one RUN cycle, count saturates at 0 -> DONE immediately after.
//   - count width $clog2(W+1); never wraps (cleared on load).
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined: port sub exists; when sub=1 at accept, b_sh loaded with ~b and
//     carry with 1 (c_in ignored); result = a - b, c_out=1 means no borrow.
//   Not defined: no sub port; pure addition with c_in.
// STRUCTURE
//   serial_adder_pkg: state enum {IDLE, RUN, DONE}, count-width localparam helper.
//   Sub-module fa_cell: combinational 1-bit full adder (x, y, c_in -> sum, c_out), one instance.
//   Shift registers, carry flop, counter and FSM live in serial_adder.
// TESTING (W=4)
//   - 3+5, c_in=0 -> out_valid 4 cycles after accept, sum=8, c_out=0.
//   - 15+1, c_in=0 -> sum=0, c_out=1; 15+15, c_in=1 -> sum=15, c_out=1.
//   - Backpressure: out_ready low 3 cycles in DONE -> sum/c_out/out_valid stable; in_valid
//     pulses during RUN/DONE ignored (in_ready=0), accepted only after return to IDLE.
//   - rst_n low for 1 cycle at RUN cycle 2 -> all outputs at reset values immediately; next op
//     7+2 completes correctly with sum=9.
//   - Exhaustive: all 512 (a,b,c_in) combos back-to-back, random out_ready -> match a+b+c_in.
//   - SERIAL_ADDER_SUB_EN: sub=1, 5-3 -> sum=2, c_out=1; 3-5 -> sum=14, c_out=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bits needed to hold 0..w; at least one bit so W=1 still has a counter.
  function automatic int cnt_w(input int w);
    int r;
    r = $clog2(w + 1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int W = 4
) ();
  import serial_adder_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
`endif

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the serial datapath cell.
// No state; the caller registers the carry between bits.
module serial_adder_fa_cell (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  // Classic sum/majority equations.
  always_comb begin
    sum   = x ^ y ^ c_in;
    c_out = (x & y) | (x & c_in) | (y & c_in);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell, registered carry, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b + 1).
module serial_adder #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  io
);
  import serial_adder_pkg::*;

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  state_t        nstate;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  sum_sh;
  logic          carry;
  logic [CW-1:0] count;

  logic          load;
  logic          step;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic          s;
  logic          co;
  logic [W-1:0]  b_ld;
  logic          c_ld;

  serial_adder_fa_cell u_fa (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .c_in  (carry),
    .sum   (s),
    .c_out (co)
  );

  // Operand B and initial carry as seen at load time.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_ld = io.sub ? ~io.b : io.b;
    c_ld = io.sub ? 1'b1 : io.c_in;
  end
`else
  always_comb begin
    b_ld = io.b;
    c_ld = io.c_in;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next state and handshake/control outputs.
  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (io.in_valid) begin
          load   = 1'b1;
          nstate = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (count == LAST) begin
          nstate = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (io.out_ready) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Shift registers, carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (load) begin
      a_sh  <= io.a;
      b_sh  <= b_ld;
      carry <= c_ld;
      count <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= (sum_sh >> 1) | (W'(s) << (W - 1));
      carry  <= co;
      if (count != LAST) begin
        count <= count + CW'(1);
      end
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.busy      = busy;
  assign io.sum       = sum_sh;
  assign io.c_out     = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks for serial_adder at W=4.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.W(W)) io ();

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(io.in_ready), 32'd1);
  endtask

  // One full operation; expectations are supplied by the caller.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic ci, input logic [W-1:0] es,
                    input logic ec, input int stall, input bit rnd);
    @(negedge clk);
    wait_ready();
    io.a        = x;
    io.b        = y;
    io.c_in     = ci;
    io.in_valid = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("run_busy", 32'(io.busy), 32'd1);
    chk("run_in_ready", 32'(io.in_ready), 32'd0);
    for (int k = 1; k < W; k++) begin
      if (rnd) io.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("early_valid", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("lat_valid", 32'(io.out_valid), 32'd1);
    chk("sum", 32'(io.sum), 32'(es));
    chk("c_out", 32'(io.c_out), 32'(ec));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(io.out_valid), 32'd1);
      chk("hold_sum", 32'(io.sum), 32'(es));
      chk("hold_c_out", 32'(io.c_out), 32'(ec));
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("ret_valid", 32'(io.out_valid), 32'd0);
    chk("ret_ready", 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    logic [W:0] e;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.c_in      = 1'b0;
    io.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    io.sub       = 1'b0;
`endif
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_sum", 32'(io.sum), 32'd0);
    chk("rst_c_out", 32'(io.c_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op(4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 0, 1'b0);
    op(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 0, 1'b0);
    op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1, 1'b0);

    // Backpressure with in_valid held high through RUN and DONE.
    @(negedge clk);
    io.a = 4'd6; io.b = 4'd7; io.c_in = 1'b0;
    io.in_valid = 1'b1;
    @(negedge clk);
    io.a = 4'd1; io.b = 4'd1;
    chk("bp_run_ready", 32'(io.in_ready), 32'd0);
    repeat (W) @(negedge clk);
    chk("bp_valid", 32'(io.out_valid), 32'd1);
    chk("bp_sum", 32'(io.sum), 32'd13);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(io.out_valid), 32'd1);
      chk("bp_hold_sum", 32'(io.sum), 32'd13);
      chk("bp_hold_c", 32'(io.c_out), 32'd0);
      chk("bp_hold_ready", 32'(io.in_ready), 32'd0);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("bp_idle_ready", 32'(io.in_ready), 32'd1);
    chk("bp_idle_busy", 32'(io.busy), 32'd0);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("bp_accept_busy", 32'(io.busy), 32'd1);
    repeat (W) @(negedge clk);
    chk("bp2_valid", 32'(io.out_valid), 32'd1);
    chk("bp2_sum", 32'(io.sum), 32'd2);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;

    // Reset during the second RUN cycle.
    io.a = 4'd3; io.b = 4'd5; io.c_in = 1'b0;
    io.in_valid = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(io.in_ready), 32'd1);
    chk("mid_rst_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(io.busy), 32'd0);
    chk("mid_rst_sum", 32'(io.sum), 32'd0);
    chk("mid_rst_c", 32'(io.c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(4'd7, 4'd2, 1'b0, 4'd9, 1'b0, 0, 1'b0);

    // Every operand combination with random out_ready.
    for (int i = 0; i < 512; i++) begin
      e = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
      op(i[3:0], i[7:4], i[8], e[3:0], e[4],
         int'($urandom_range(0, 2)), 1'b1);
    end

`ifdef SERIAL_ADDER_SUB_EN
    io.sub = 1'b1;
    op(4'd5, 4'd3, 1'b0, 4'd2, 1'b1, 0, 1'b0);
    op(4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 0, 1'b0);
    io.sub = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
